// File: rtl/des_pkg.sv
// Shared definitions for the DES S-box layer: substitution tables, P permutation,
// FSM state encoding and the LANES legality check.
package des_pkg;

  localparam int unsigned NBOX = 8;

  // One entry per box, 64 nibbles indexed row*16+col; element 0 is the leftmost nibble.
  localparam logic [0:63][3:0] SBOX [NBOX] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  // Output bit i (1 = MSB) takes input bit PERM[i-1] (1 = MSB).
  localparam logic [5:0] PERM [32] = '{
    6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
    6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
    6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
    6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
  };

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  function automatic bit lanes_ok(input int unsigned n);
    return (n == 1) || (n == 2) || (n == 4) || (n == 8);
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) begin
      y[5'(31 - i)] = x[5'(32 - int'(PERM[i]))];
    end
    return y;
  endfunction

endpackage

// File: rtl/des_sbox_sel.sv
// Single-lane S-box lookup: picks box `box` and maps a 6-bit chunk to its 4-bit value.
module des_sbox_sel
  import des_pkg::*;
(
  input  logic [5:0] chunk,
  input  logic [2:0] box,
  output logic [3:0] val_c
);

  // Outer bits select the row, inner four bits the column.
  assign val_c = SBOX[box][{chunk[5], chunk[0], chunk[4:1]}];

endmodule

// File: rtl/des_sbox_unit.sv
// Time-shared DES S-box substitution layer, LANES boxes per cycle, valid/ready on both sides.
// Optional P permutation on the output when DES_SBOX_PERM_EN is defined.
module des_sbox_unit
  import des_pkg::*;
#(
  parameter int unsigned LANES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] din,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] dout,
  output logic        busy
);

  localparam int unsigned STEPS  = 8 / LANES;
  localparam int unsigned STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  if (!lanes_ok(LANES)) begin : g_lanes_check
    $error("des_sbox_unit: LANES must be 1, 2, 4 or 8");
  end

  state_t            state;
  logic [STEP_W-1:0] step;
  logic [47:0]       data;
  logic [31:0]       result;

  logic [2:0] box_idx [LANES];
  logic [5:0] chunk   [LANES];
  logic [3:0] nib     [LANES];

  // Lane l handles box step*LANES+l; with LANES=8 the index is a constant per lane.
  for (genvar l = 0; l < int'(LANES); l++) begin : g_lane
    assign box_idx[l] = 3'(int'(step) * int'(LANES) + l);
    assign chunk[l]   = data[6'(47 - 6 * int'(box_idx[l])) -: 6];

    des_sbox_sel u_sel (
      .chunk(chunk[l]),
      .box  (box_idx[l]),
      .val_c(nib[l])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      step   <= '0;
      data   <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data  <= din;
            step  <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          for (int l = 0; l < int'(LANES); l++) begin
            result[5'(31 - 4 * int'(box_idx[l])) -: 4] <= nib[l];
          end
          if (step == LAST_STEP) begin
            step  <= '0;
            state <= DONE;
          end else begin
            step <= step + STEP_W'(1);
          end
        end
        DONE: begin
          // A new word may be taken in the same cycle the result is consumed.
          if (out_ready) begin
            if (in_valid) begin
              data  <= din;
              step  <= '0;
              state <= BUSY;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign in_ready  = !rst && ((state == IDLE) || ((state == DONE) && out_ready));

`ifdef DES_SBOX_PERM_EN
  assign dout = p_perm(result);
`else
  assign dout = result;
`endif

endmodule

// File: tb/tb_des_sbox_unit.sv
// Bench for des_sbox_unit: known vectors, handshake corner cases, random and exhaustive
// sweeps against an arithmetic reference built from its own copy of the DES tables.
module tb_des_sbox_unit;

  parameter int unsigned LANES = 2;
  localparam int unsigned STEPS = 8 / LANES;

  localparam int ST [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  localparam int PT [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                             2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};

  typedef struct {
    logic [47:0] d;
    logic [31:0] raw;
    bit          pk;
    logic [31:0] perm;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] din;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dout;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  des_sbox_unit #(.LANES(LANES)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din      (din),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout     (dout),
    .busy     (busy)
  );

  function automatic logic [31:0] p_ref(input logic [31:0] x);
    logic [31:0] y;
    y = '0;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - PT[i])];
    return y;
  endfunction

  function automatic logic [31:0] ref_dout(input logic [47:0] d);
    logic [31:0] r;
    int c, row, col;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      c   = int'(d[6'(47 - 6 * b) -: 6]);
      row = (c / 32) * 2 + (c % 2);
      col = (c / 2) % 16;
      r   = {r[27:0], 4'(ST[b][row * 16 + col])};
    end
`ifdef DES_SBOX_PERM_EN
    r = p_ref(r);
`endif
    return r;
  endfunction

  function automatic logic [47:0] rnd48();
    return 48'({$urandom(), $urandom()});
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Wait for out_valid with a cycle bound; returns edges elapsed after the accept edge.
  task automatic wait_done(output int lat, output int busy_n, output int ir_bad);
    lat = 0; busy_n = 0; ir_bad = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_n++;
      if (in_ready !== 1'b0) ir_bad++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_block(input logic [47:0] d, input logic [31:0] exp, input string nm);
    int lat, busy_n, ir_bad;
    @(negedge clk);
    chk({nm, "_in_ready_idle"}, 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    din      = d;
    @(negedge clk);
    in_valid = 1'b0;
    din      = rnd48();
    wait_done(lat, busy_n, ir_bad);
    chk({nm, "_latency"}, 64'(lat), 64'(STEPS));
    chk({nm, "_busy_cycles"}, 64'(busy_n), 64'(STEPS));
    chk({nm, "_in_ready_busy"}, 64'(ir_bad), 64'(0));
    chk({nm, "_dout"}, 64'(dout), 64'(exp));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_out_valid_drop"}, 64'(out_valid), 64'(0));
  endtask

  initial begin
    vec_t        tbl [5];
    logic [47:0] d1, d2, d3;
    logic [31:0] e;
    int          lat, busy_n, ir_bad, stall_bad;

    tbl[0] = '{d: 48'h000000000000, raw: 32'hEFA72C4D, pk: 1'b0, perm: 32'h0};
    tbl[1] = '{d: 48'hFFFFFFFFFFFF, raw: 32'hD9CE3DCB, pk: 1'b0, perm: 32'h0};
    tbl[2] = '{d: 48'h6117BA866527, raw: 32'h5C82B597, pk: 1'b1, perm: 32'h234AA9BB};
    tbl[3] = '{d: 48'h000000000001, raw: 32'hEFA72C41, pk: 1'b0, perm: 32'h0};
    tbl[4] = '{d: 48'h800000000000, raw: 32'h4FA72C4D, pk: 1'b0, perm: 32'h0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; din = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_dout", 64'(dout), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      e = tbl[i].raw;
`ifdef DES_SBOX_PERM_EN
      e = tbl[i].pk ? tbl[i].perm : p_ref(tbl[i].raw);
`endif
      run_block(tbl[i].d, e, $sformatf("vec%0d", i));
    end

    // Input offered during BUSY is ignored; result then stalls under out_ready=0.
    d1 = rnd48();
    d2 = ~d1;
    @(negedge clk);
    in_valid = 1'b1; din = d1;
    @(negedge clk);
    din = d2;
    wait_done(lat, busy_n, ir_bad);
    chk("stall_latency", 64'(lat), 64'(STEPS));
    chk("busy_ignore_dout", 64'(dout), 64'(ref_dout(d1)));
    stall_bad = 0;
    for (int i = 0; i < 10; i++) begin
      din = rnd48();
      @(negedge clk);
      if (dout !== ref_dout(d1) || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0)
        stall_bad++;
    end
    chk("stall_hold", 64'(stall_bad), 64'(0));

    // Release with a new word waiting: captured on the same edge.
    d2 = rnd48();
    din = d2; out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_busy", 64'(busy), 64'(1));
    chk("b2b_out_valid", 64'(out_valid), 64'(0));
    wait_done(lat, busy_n, ir_bad);
    chk("b2b_latency", 64'(lat), 64'(STEPS));
    chk("b2b_dout", 64'(dout), 64'(ref_dout(d2)));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of BUSY (step 1).
    @(negedge clk);
    in_valid = 1'b1; din = rnd48();
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_busy_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy_busy", 64'(busy), 64'(0));
    chk("rst_busy_dout", 64'(dout), 64'(0));
    chk("rst_busy_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    d3 = rnd48();
    run_block(d3, ref_dout(d3), "post_rst_busy");

    // Reset while a finished result is presented.
    @(negedge clk);
    in_valid = 1'b1; din = rnd48();
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(lat, busy_n, ir_bad);
    chk("pre_rst_done_valid", 64'(out_valid), 64'(1));
    rst = 1'b1;
    #1;
    chk("rst_done_out_valid", 64'(out_valid), 64'(0));
    chk("rst_done_dout", 64'(dout), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    d3 = rnd48();
    run_block(d3, ref_dout(d3), "post_rst_done");

    for (int i = 0; i < 150; i++) begin
      d1 = rnd48();
      run_block(d1, ref_dout(d1), $sformatf("rand%0d", i));
    end

    for (int b = 0; b < 8; b++) begin
      for (int v = 0; v < 64; v++) begin
        d1 = 48'(v) << (42 - 6 * b);
        run_block(d1, ref_dout(d1), $sformatf("sweep_s%0d_%0d", b + 1, v));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
